// File: rtl/vram_arbiter_pkg.sv
// Shared VGA timing constants and types for the VRAM arbiter slice.
// Defaults describe 640x480 at a 25.175 MHz pixel clock.
package vga_pkg;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned DATA_W   = 12;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef enum logic [1:0] {RD_NONE, RD_DISP, RD_HOST} rd_owner_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// Host-side valid/ready request bus plus read-return channel of the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 12
);
    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/vram_arbiter_scan_addr_gen.sv
// Scanout address counter: advances once per active pixel, wraps at frame end,
// and flags the first scanout read of each frame.
module vram_scan_addr_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int unsigned HC_W     = $clog2(H_TOTAL),
    parameter int unsigned VC_W     = $clog2(V_TOTAL)
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic              disp_slot,
    input  logic [HC_W-1:0]   h_count,
    input  logic [VC_W-1:0]   v_count,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              frame_start
);
    localparam logic [HC_W-1:0]   H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]   V_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic              frame_start_q, frame_start_d;

    always_comb begin
        scan_addr_d = scan_addr_q;
        // Folding back after the last pixel keeps the counter inside the frame buffer
        // through v-blank; the explicit frame wrap realigns it with the timing block.
        if (h_count == H_LAST && v_count == V_LAST) begin
            scan_addr_d = '0;
        end else if (disp_slot) begin
            scan_addr_d = (scan_addr_q == A_LAST) ? '0 : scan_addr_q + ADDR_W'(1);
        end
        frame_start_d = disp_slot && (h_count == '0) && (v_count == '0);
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            scan_addr_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            scan_addr_q   <= scan_addr_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign scan_addr   = scan_addr_q;
    assign frame_start = frame_start_q;
endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port pixel RAM between VGA scanout and a host port.
// Scanout owns every active-video slot; host requests fill all blanking slots.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int unsigned DATA_W   = vga_pkg::DATA_W,
    parameter int unsigned ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int unsigned HC_W     = $clog2(H_TOTAL),
    parameter int unsigned VC_W     = $clog2(V_TOTAL)
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic [HC_W-1:0]   h_count,
    input  logic [VC_W-1:0]   v_count,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_start,
    vram_arbiter_if.slave     host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [HC_W-1:0] H_ACT_C = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_ACT_C = VC_W'(V_ACTIVE);

    logic              disp_slot;
    logic [ADDR_W-1:0] scan_addr;
    rd_owner_e         rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              pix_valid_q, pix_valid_d;
    logic              host_rvalid_q, host_rvalid_d;

    always_comb disp_slot = (h_count < H_ACT_C) && (v_count < V_ACT_C);

    vram_scan_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .ADDR_W   (ADDR_W),
        .HC_W     (HC_W),
        .VC_W     (VC_W)
    ) u_scan_addr_gen (
        .clk_in      (clk_in),
        .resetn      (resetn),
        .disp_slot   (disp_slot),
        .h_count     (h_count),
        .v_count     (v_count),
        .scan_addr   (scan_addr),
        .frame_start (frame_start)
    );

    always_comb begin
        mem_addr        = host.host_addr;
        mem_we          = 1'b0;
        mem_wdata       = host.host_wdata;
        host.host_ready = 1'b1;
        rd_owner_d      = RD_NONE;
        if (disp_slot) begin
            mem_addr        = scan_addr;
            host.host_ready = 1'b0;
            rd_owner_d      = RD_DISP;
        end else if (host.host_valid) begin
            mem_we     = host.host_we;
            rd_owner_d = host.host_we ? RD_NONE : RD_HOST;
        end
    end

    // rd_owner_q tags whose address went out last cycle, i.e. who owns mem_rdata now.
    always_comb begin
        pix_data_d    = '0;
        pix_valid_d   = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        case (rd_owner_q)
            RD_DISP: begin
                pix_data_d  = mem_rdata;
                pix_valid_d = 1'b1;
            end
            RD_HOST: begin
                host_rdata_d  = mem_rdata;
                host_rvalid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            rd_owner_q    <= RD_NONE;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            rd_owner_q    <= rd_owner_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign pix_data         = pix_data_q;
    assign pix_valid        = pix_valid_q;
    assign host.host_rdata  = host_rdata_q;
    assign host.host_rvalid = host_rvalid_q;
endmodule
